axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// AXI-Lite master: one transaction in flight, per-phase timeout abort.
// All AXI and response outputs come straight from registers.
module axi_lite_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
    } state_e;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic [7:0] cnt_inc;
    logic       expired;
    logic       aw_fin;
    logic       w_fin;
    logic       waiting;
    logic       abort;

    // A channel counts as finished once its valid has dropped or it is
    // handshaking this cycle; completion wins over an expiring counter.
    assign cnt_inc = cnt_q + 8'd1;
    assign expired = (cnt_inc == TMO);
    assign aw_fin  = !awvalid_q || awready;
    assign w_fin   = !wvalid_q || wready;
    assign waiting = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                     (state_q == RD_REQ) || (state_q == RD_RESP);

    assign cmd_ready   = (state_q == IDLE);
    assign awaddr      = awaddr_q;
    assign awvalid     = awvalid_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign wvalid      = wvalid_q;
    assign bready      = bready_q;
    assign araddr      = araddr_q;
    assign arvalid     = arvalid_q;
    assign rready      = rready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = cmd_we ? WR_REQ : RD_REQ;
            WR_REQ:  if (aw_fin && w_fin) state_d = WR_RESP;
                     else if (expired)    state_d = DONE;
            WR_RESP: if (bvalid || expired) state_d = DONE;
            RD_REQ:  if (arready)      state_d = RD_RESP;
                     else if (expired) state_d = DONE;
            RD_RESP: if (rvalid || expired) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the phase counter
    always_comb begin
        abort         = 1'b0;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d = (state_d != state_q || !waiting) ? 8'd0 : cnt_inc;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_we) begin
                    awaddr_d  = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (cmd_valid) begin
                    araddr_d  = cmd_addr;
                    arvalid_d = 1'b1;
                end
            end
            WR_REQ: begin
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (aw_fin && w_fin) bready_d = 1'b1;
                else if (expired)    abort    = 1'b1;
            end
            WR_RESP: begin
                if (bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'd0;
                    rsp_resp_d    = bresp;
                    rsp_timeout_d = 1'b0;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            RD_REQ: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            RD_RESP: begin
                if (rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = rdata;
                    rsp_resp_d    = rresp;
                    rsp_timeout_d = 1'b0;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            DONE: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = 32'd0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
        end
    end

    // Output and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: delay-programmable AXI-Lite slave plus a
// transaction-level model predicting response, latency and channel activity.
module tb_axi_lite_master;

    localparam int T   = 16;
    localparam int LIM = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [3:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    axi_lite_master #(.ADDR_WIDTH(4), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Slave address map: unaligned -> DECERR, 0xC -> SLVERR, else OKAY
    function automatic logic [1:0] slave_resp(input logic [3:0] a);
        if (a[1:0] != 2'b00) return 2'b11;
        if (a == 4'hC) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    logic [31:0] mem_s [4];
    logic [31:0] mem_m [4];

    int aw_dly, w_dly, b_dly, ar_dly, r_dly;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit aw_got, w_got, wr_applied, b_done, ar_got, r_done;
    logic [1:0]  wr_resp;
    logic [3:0]  cap_awaddr, cap_araddr, cap_wstrb;
    logic [31:0] cap_wdata;

    bit prev_aw, prev_w, prev_ar;
    int n_aw, n_w, n_ar;
    int aw_hi, w_hi, ar_hi, b_hi, r_hi;
    bit err_bready, err_overlap;

    task automatic clear_slave();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; wr_applied = 0; b_done = 0;
        ar_got = 0; r_done = 0;
        n_aw = 0; n_w = 0; n_ar = 0;
        aw_hi = 0; w_hi = 0; ar_hi = 0; b_hi = 0; r_hi = 0;
        err_bready = 0; err_overlap = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    endtask

    // Slave responder and channel monitor, active on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0;
            arready = 0; rvalid = 0; rresp = 0; rdata = 0;
            prev_aw = 0; prev_w = 0; prev_ar = 0;
            wr_applied = 0; ar_got = 0;
        end else begin
            if (prev_aw && awready) n_aw++;
            if (prev_w && wready) n_w++;
            if (prev_ar && arready) n_ar++;
            if (bready && (n_aw == 0 || n_w == 0)) err_bready = 1;
            if (arvalid && (awvalid || wvalid)) err_overlap = 1;
            if (rready && bready) err_overlap = 1;
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (arvalid) ar_hi++;
            if (bready) b_hi++;
            if (rready) r_hi++;
            prev_aw = awvalid; prev_w = wvalid; prev_ar = arvalid;

            if (wr_applied && !b_done) begin
                if (bvalid) begin
                    if (!bready) begin bvalid = 0; b_done = 1; end
                end else begin
                    if (b_cnt >= b_dly) begin bvalid = 1; bresp = wr_resp; end
                    b_cnt++;
                end
            end
            if (awvalid && !aw_got) begin
                if (aw_cnt >= aw_dly) begin
                    awready = 1; aw_got = 1; cap_awaddr = awaddr;
                end
                aw_cnt++;
            end else awready = 0;
            if (wvalid && !w_got) begin
                if (w_cnt >= w_dly) begin
                    wready = 1; w_got = 1;
                    cap_wdata = wdata; cap_wstrb = wstrb;
                end
                w_cnt++;
            end else wready = 0;
            if (aw_got && w_got && !wr_applied) begin
                wr_applied = 1;
                wr_resp = slave_resp(cap_awaddr);
                if (wr_resp == 2'b00)
                    mem_s[cap_awaddr[3:2]] =
                        merge(mem_s[cap_awaddr[3:2]], cap_wdata, cap_wstrb);
            end

            if (ar_got && !r_done) begin
                if (rvalid) begin
                    if (!rready) begin rvalid = 0; r_done = 1; end
                end else begin
                    if (r_cnt >= r_dly) begin
                        rvalid = 1;
                        rresp = slave_resp(cap_araddr);
                        rdata = (rresp == 2'b11) ? 32'd0 : mem_s[cap_araddr[3:2]];
                    end
                    r_cnt++;
                end
            end
            if (arvalid && !ar_got) begin
                if (ar_cnt >= ar_dly) begin
                    arready = 1; ar_got = 1; cap_araddr = araddr;
                end
                ar_cnt++;
            end else arready = 0;
        end
    end

    task automatic send_cmd(input logic we, input logic [3:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            input int daw, input int dw, input int db,
                            input int dar, input int dr);
        tick();
        chk("cmd_ready_idle", cmd_ready, 1);
        aw_dly = daw; w_dly = dw; b_dly = db; ar_dly = dar; r_dly = dr;
        clear_slave();
        cmd_valid = 1; cmd_we = we; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s;
        tick();
        cmd_valid = 0;
        chk("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic run_txn(input logic we, input logic [3:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input int daw, input int dw, input int db,
                           input int dar, input int dr);
        int k1, k2, lat, n, hold;
        int e_aw, e_w, e_ar, e_b, e_r;
        int h_aw, h_w, h_ar;
        logic to;
        logic [1:0] resp;
        logic [31:0] rd;
        resp = slave_resp(a);
        rd = 0; to = 0; lat = 0;
        e_aw = 0; e_w = 0; e_ar = 0; e_b = 0; e_r = 0;
        h_aw = 0; h_w = 0; h_ar = 0;
        if (we) begin
            k1 = ((daw > dw) ? daw : dw) + 1;
            e_aw = (daw + 1 > T) ? T : daw + 1;
            e_w = (dw + 1 > T) ? T : dw + 1;
            h_aw = (daw + 1 <= T); h_w = (dw + 1 <= T);
            if (k1 > T) begin
                lat = T; to = 1;
            end else begin
                if (resp == 2'b00) mem_m[a[3:2]] = merge(mem_m[a[3:2]], d, s);
                k2 = db + 1;
                e_b = (k2 > T) ? T : k2;
                if (k2 > T) begin lat = k1 + T; to = 1; end
                else lat = k1 + k2;
            end
        end else begin
            k1 = dar + 1;
            e_ar = (k1 > T) ? T : k1;
            h_ar = (k1 <= T);
            if (k1 > T) begin
                lat = T; to = 1;
            end else begin
                k2 = dr + 1;
                e_r = (k2 > T) ? T : k2;
                if (k2 > T) begin lat = k1 + T; to = 1; end
                else lat = k1 + k2;
                if (resp != 2'b11) rd = mem_m[a[3:2]];
            end
        end
        if (to) begin resp = 2'b10; rd = 0; end

        send_cmd(we, a, d, s, daw, dw, db, dar, dr);
        n = 0;
        while (rsp_valid !== 1'b1 && n < LIM) begin
            tick();
            n++;
        end
        chk("rsp_valid_wait", rsp_valid, 1);
        if (rsp_valid !== 1'b1) return;
        chk("latency", n, lat);
        chk("rsp_rdata", rsp_rdata, rd);
        chk("rsp_resp", rsp_resp, resp);
        chk("rsp_timeout", rsp_timeout, to);
        chk("aw_hs", n_aw, h_aw);
        chk("w_hs", n_w, h_w);
        chk("ar_hs", n_ar, h_ar);
        if (h_aw) chk("awaddr", cap_awaddr, a);
        if (h_w) chk("wdata", cap_wdata, d);
        if (h_w) chk("wstrb", cap_wstrb, s);
        if (h_ar) chk("araddr", cap_araddr, a);
        chk("awvalid_cycles", aw_hi, e_aw);
        chk("wvalid_cycles", w_hi, e_w);
        chk("arvalid_cycles", ar_hi, e_ar);
        chk("bready_cycles", b_hi, e_b);
        chk("rready_cycles", r_hi, e_r);
        chk("bready_early", err_bready, 0);
        chk("overlap", err_overlap, 0);
        hold = $urandom_range(1, 3);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("rsp_hold_valid", rsp_valid, 1);
            chk("rsp_hold_rdata", rsp_rdata, rd);
            chk("rsp_hold_resp", {rsp_timeout, rsp_resp}, {to, resp});
            chk("cmd_ready_done", cmd_ready, 0);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("rsp_released", rsp_valid, 0);
        chk("cmd_ready_after", cmd_ready, 1);
    endtask

    function automatic int rdly();
        if ($urandom_range(0, 5) == 0) return $urandom_range(12, 20);
        return $urandom_range(0, 4);
    endfunction

    initial begin
        logic [3:0] a;
        rst_n = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0;
        cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        clear_slave();
        bresp = 0; rresp = 0; rdata = 0;
        mem_s[0] = 0; mem_s[1] = 32'h3; mem_s[2] = 32'h2; mem_s[3] = 32'hA5A50000;
        for (int i = 0; i < 4; i++) mem_m[i] = mem_s[i];
        repeat (3) tick();
        chk("reset_ctl", {awvalid, wvalid, bready, arvalid, rready,
                          rsp_valid, rsp_timeout}, 0);
        chk("reset_data", {awaddr, araddr, wstrb, rsp_resp}, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_rdata", rsp_rdata, 0);
        rst_n = 1;
        tick();
        chk("cmd_ready_reset", cmd_ready, 1);

        run_txn(1, 4'h0, 32'hFFFFFFFF, 4'hF, 1, 1, 0, 0, 0);
        run_txn(0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 2, 1);
        run_txn(1, 4'h2, 32'h12345678, 4'hF, 0, 0, 1, 0, 0);
        run_txn(0, 4'h2, 32'h0, 4'h0, 0, 0, 0, 0, 1);
        run_txn(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 200, 0);
        run_txn(1, 4'h0, 32'h0BADF00D, 4'h5, 3, 0, 0, 0, 0);
        run_txn(1, 4'hC, 32'h11111111, 4'hF, 0, 0, 0, 0, 0);
        run_txn(0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0, 200);
        run_txn(1, 4'h0, 32'h77665544, 4'h3, 0, 0, 200, 0, 0);

        send_cmd(1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 200, 0, 0);
        mem_m[1] = merge(mem_m[1], 32'hDEADBEEF, 4'hF);
        tick();
        chk("bready_in_resp", bready, 1);
        tick();
        rst_n = 0;
        tick();
        chk("midreset_ctl", {awvalid, wvalid, bready, arvalid, rready,
                             rsp_valid}, 0);
        chk("midreset_addr", {awaddr, araddr, wstrb}, 0);
        chk("midreset_wdata", wdata, 0);
        rst_n = 1;
        tick();
        chk("cmd_ready_postreset", cmd_ready, 1);
        run_txn(0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 0, 0);
        run_txn(0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 1, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) a = 4'($urandom);
            else a = {2'($urandom), 2'b00};
            run_txn(1'($urandom), a, $urandom, 4'($urandom),
                    rdly(), rdly(), rdly(), rdly(), rdly());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
